// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller: one shared full-subtractor cell computes
// a - b - borrow_in LSB-first over WIDTH cycles behind a start/busy/done handshake.
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             brw_q, brw_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q, bo_d;

    logic             hs_d, hs_bo, cell_d, cell_bo;

    // Two half-subtractors chained, borrows merged with an OR.
    always_comb begin
        hs_d    = a_sh_q[0] ^ b_sh_q[0];
        hs_bo   = ~a_sh_q[0] & b_sh_q[0];
        cell_d  = hs_d ^ brw_q;
        cell_bo = hs_bo | (~hs_d & brw_q);
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bo_d     = bo_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = borrow_in;
                    cnt_d   = '0;
                    state_d = StRun;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {cell_d, res_sh_q[WIDTH-1:1]};
                brw_d    = cell_bo;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    diff_d  = {cell_d, res_sh_q[WIDTH-1:1]};
                    bo_d    = cell_bo;
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bo_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bo_q     <= bo_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bo_q;

endmodule
